// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the multi-cycle ALU control sequencer:
// ALUop / funct encodings, ALU control codes, operation kinds and FSM states.
package alu_seq_pkg;

    // Main-decoder ALUop encodings
    localparam logic [4:0] ALUOP_ADD   = 5'd0;
    localparam logic [4:0] ALUOP_SUB   = 5'd1;
    localparam logic [4:0] ALUOP_RTYPE = 5'd2;
    localparam logic [4:0] ALUOP_ADDU  = 5'd3;
    localparam logic [4:0] ALUOP_AND   = 5'd4;
    localparam logic [4:0] ALUOP_OR    = 5'd5;
    localparam logic [4:0] ALUOP_XOR   = 5'd6;
    localparam logic [4:0] ALUOP_SLT   = 5'd7;
    localparam logic [4:0] ALUOP_SLTU  = 5'd8;
    localparam logic [4:0] ALUOP_LUI   = 5'd9;

    // R-type function field encodings
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;
    localparam logic [5:0] FN_X32   = 6'h32;

    // ALU control codes presented to the EX stage
    localparam logic [5:0] ALUC_AND   = 6'h00;
    localparam logic [5:0] ALUC_OR    = 6'h01;
    localparam logic [5:0] ALUC_ADD   = 6'h02;
    localparam logic [5:0] ALUC_ADDU  = 6'h03;
    localparam logic [5:0] ALUC_XOR   = 6'h04;
    localparam logic [5:0] ALUC_SUB   = 6'h06;
    localparam logic [5:0] ALUC_SLT   = 6'h07;
    localparam logic [5:0] ALUC_SLTU  = 6'h08;
    localparam logic [5:0] ALUC_LUI   = 6'h09;
    localparam logic [5:0] ALUC_SLL1  = 6'h0A;
    localparam logic [5:0] ALUC_SLL2  = 6'h0B;
    localparam logic [5:0] ALUC_SLL8  = 6'h0C;
    localparam logic [5:0] ALUC_SRL1  = 6'h0D;
    localparam logic [5:0] ALUC_SRL2  = 6'h0E;
    localparam logic [5:0] ALUC_SRL8  = 6'h0F;
    localparam logic [5:0] ALUC_SRA1  = 6'h10;
    localparam logic [5:0] ALUC_SRA2  = 6'h11;
    localparam logic [5:0] ALUC_SRA8  = 6'h12;
    localparam logic [5:0] ALUC_MULTU = 6'h13;
    localparam logic [5:0] ALUC_X32   = 6'h32;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_MULT = 2'd2} seq_state_t;
    typedef enum logic [1:0] {KIND_SINGLE = 2'd0, KIND_SHIFT = 2'd1, KIND_MULT = 2'd2} op_kind_t;
    typedef enum logic [1:0] {SH_SLL = 2'd0, SH_SRL = 2'd1, SH_SRA = 2'd2} shift_cls_t;
    typedef enum logic [1:0] {AMT1 = 2'd0, AMT2 = 2'd1, AMT8 = 2'd2} step_amt_t;

    // Map a shift class and one primitive shift amount onto its ALU control code
    function automatic logic [5:0] shift_code(input shift_cls_t cls, input step_amt_t amt);
        logic [5:0] code;
        case (cls)
            SH_SRL: begin
                case (amt)
                    AMT8:    code = ALUC_SRL8;
                    AMT2:    code = ALUC_SRL2;
                    default: code = ALUC_SRL1;
                endcase
            end
            SH_SRA: begin
                case (amt)
                    AMT8:    code = ALUC_SRA8;
                    AMT2:    code = ALUC_SRA2;
                    default: code = ALUC_SRA1;
                endcase
            end
            default: begin
                case (amt)
                    AMT8:    code = ALUC_SLL8;
                    AMT2:    code = ALUC_SLL2;
                    default: code = ALUC_SLL1;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Operation-in / step-out bus between the ID-stage decoder and the sequencer.
interface alu_seq_ctrl_if #(
    parameter int SHAMT_W = 5,
    parameter int CTRL_W  = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [4:0]         ALUop;
    logic [5:0]         functionCode;
    logic [SHAMT_W-1:0] Shamt;
    logic               hold;
    logic               flush;
    logic               step_valid;
    logic [CTRL_W-1:0]  ALUctrl;
    logic               step_first;
    logic               step_last;
    logic               busy;

    modport master (
        output in_valid, ALUop, functionCode, Shamt, hold, flush,
        input  in_ready, step_valid, ALUctrl, step_first, step_last, busy
    );

    modport slave (
        input  in_valid, ALUop, functionCode, Shamt, hold, flush,
        output in_ready, step_valid, ALUctrl, step_first, step_last, busy
    );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational decode of ALUop/funct into a base control code, the kind of
// sequence the operation needs, and the shift class for shift operations.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [4:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [5:0] o_base_code,
    output op_kind_t   o_kind,
    output shift_cls_t o_shift_cls
);

    // Table decode; anything unrecognised becomes a single 0x0 step
    always_comb begin
        o_base_code = ALUC_AND;
        o_kind      = KIND_SINGLE;
        o_shift_cls = SH_SLL;
        case (i_alu_op)
            ALUOP_ADD:  o_base_code = ALUC_ADD;
            ALUOP_SUB:  o_base_code = ALUC_SUB;
            ALUOP_ADDU: o_base_code = ALUC_ADDU;
            ALUOP_AND:  o_base_code = ALUC_AND;
            ALUOP_OR:   o_base_code = ALUC_OR;
            ALUOP_XOR:  o_base_code = ALUC_XOR;
            ALUOP_SLT:  o_base_code = ALUC_SLT;
            ALUOP_SLTU: o_base_code = ALUC_SLTU;
            ALUOP_LUI:  o_base_code = ALUC_LUI;
            ALUOP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_base_code = ALUC_ADD;
                    FN_ADDU: o_base_code = ALUC_ADDU;
                    FN_SUBU: o_base_code = ALUC_SUB;
                    FN_AND:  o_base_code = ALUC_AND;
                    FN_OR:   o_base_code = ALUC_OR;
                    FN_XOR:  o_base_code = ALUC_XOR;
                    FN_SLT:  o_base_code = ALUC_SLT;
                    FN_SLTU: o_base_code = ALUC_SLTU;
                    FN_X32:  o_base_code = ALUC_X32;
                    FN_MFHI, FN_MFLO: o_base_code = ALUC_AND;
                    FN_MULTU: begin
                        o_kind      = KIND_MULT;
                        o_base_code = ALUC_MULTU;
                    end
                    FN_SLL: begin
                        o_kind      = KIND_SHIFT;
                        o_shift_cls = SH_SLL;
                    end
                    FN_SRL: begin
                        o_kind      = KIND_SHIFT;
                        o_shift_cls = SH_SRL;
                    end
                    FN_SRA: begin
                        o_kind      = KIND_SHIFT;
                        o_shift_cls = SH_SRA;
                    end
                    default: o_base_code = ALUC_AND;
                endcase
            end
            default: o_base_code = ALUC_AND;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Registered multi-cycle ALU control sequencer. Accepts one operation when
// idle, then emits one ALU control step per cycle: shifts are split greedily
// into 8/2/1 primitives, MULTU is repeated MULT_CYCLES times.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int SHAMT_W     = 5,
    parameter int MULT_CYCLES = 4,
    parameter int CTRL_W      = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_ctrl_if.slave  bus
);

    seq_state_t         r_state, w_state_nx;
    shift_cls_t         r_cls, w_cls_nx;
    logic [SHAMT_W-1:0] r_rem, w_rem_nx;
    logic [3:0]         r_mcnt, w_mcnt_nx;
    logic               r_valid, w_valid_nx;
    logic               r_first, w_first_nx;
    logic               r_last, w_last_nx;
    logic [CTRL_W-1:0]  r_ctrl, w_ctrl_nx;

    logic               w_ready;
    logic               w_accept;
    logic [5:0]         w_base;
    op_kind_t           w_kind;
    shift_cls_t         w_dec_cls;

    logic [SHAMT_W-1:0] w_split_src;
    logic [SHAMT_W-1:0] w_amt_val;
    logic [SHAMT_W-1:0] w_split_rem;
    step_amt_t          w_amt;

    alu_seq_decode u_decode (
        .i_alu_op    (bus.ALUop),
        .i_funct     (bus.functionCode),
        .o_base_code (w_base),
        .o_kind      (w_kind),
        .o_shift_cls (w_dec_cls)
    );

    assign w_ready  = (r_state == ST_IDLE) & ~bus.hold & ~bus.flush;
    assign w_accept = bus.in_valid & w_ready;

    // Greedy splitter: largest primitive not exceeding the remaining amount
    always_comb begin
        w_split_src = (r_state == ST_SHIFT) ? r_rem : bus.Shamt;
        if (w_split_src >= SHAMT_W'(8)) begin
            w_amt     = AMT8;
            w_amt_val = SHAMT_W'(8);
        end else if (w_split_src >= SHAMT_W'(2)) begin
            w_amt     = AMT2;
            w_amt_val = SHAMT_W'(2);
        end else begin
            w_amt     = AMT1;
            w_amt_val = SHAMT_W'(1);
        end
        w_split_rem = w_split_src - w_amt_val;
    end

    // Next-state and next-step logic; flush beats hold, hold freezes everything
    always_comb begin
        w_state_nx = r_state;
        w_cls_nx   = r_cls;
        w_rem_nx   = r_rem;
        w_mcnt_nx  = r_mcnt;
        w_valid_nx = r_valid;
        w_first_nx = r_first;
        w_last_nx  = r_last;
        w_ctrl_nx  = r_ctrl;
        if (bus.flush) begin
            w_state_nx = ST_IDLE;
            w_rem_nx   = '0;
            w_mcnt_nx  = 4'd0;
            w_valid_nx = 1'b0;
            w_first_nx = 1'b0;
            w_last_nx  = 1'b0;
        end else if (bus.hold) begin
            w_state_nx = r_state;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_valid_nx = 1'b1;
                        w_first_nx = 1'b1;
                        case (w_kind)
                            KIND_SHIFT: begin
                                if (bus.Shamt == '0) begin
                                    w_ctrl_nx = CTRL_W'(ALUC_AND);
                                    w_last_nx = 1'b1;
                                end else begin
                                    w_ctrl_nx = CTRL_W'(shift_code(w_dec_cls, w_amt));
                                    w_cls_nx  = w_dec_cls;
                                    w_rem_nx  = w_split_rem;
                                    if (w_split_rem == '0) begin
                                        w_last_nx = 1'b1;
                                    end else begin
                                        w_last_nx  = 1'b0;
                                        w_state_nx = ST_SHIFT;
                                    end
                                end
                            end
                            KIND_MULT: begin
                                w_ctrl_nx = CTRL_W'(ALUC_MULTU);
                                if (MULT_CYCLES <= 1) begin
                                    w_last_nx = 1'b1;
                                end else begin
                                    w_last_nx  = 1'b0;
                                    w_mcnt_nx  = 4'(MULT_CYCLES - 1);
                                    w_state_nx = ST_MULT;
                                end
                            end
                            default: begin
                                w_ctrl_nx = CTRL_W'(w_base);
                                w_last_nx = 1'b1;
                            end
                        endcase
                    end else begin
                        w_valid_nx = 1'b0;
                        w_first_nx = 1'b0;
                        w_last_nx  = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    w_valid_nx = 1'b1;
                    w_first_nx = 1'b0;
                    w_ctrl_nx  = CTRL_W'(shift_code(r_cls, w_amt));
                    w_rem_nx   = w_split_rem;
                    if (w_split_rem == '0) begin
                        w_last_nx  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_last_nx  = 1'b0;
                    end
                end
                ST_MULT: begin
                    w_valid_nx = 1'b1;
                    w_first_nx = 1'b0;
                    w_ctrl_nx  = CTRL_W'(ALUC_MULTU);
                    w_mcnt_nx  = r_mcnt - 4'd1;
                    if (r_mcnt == 4'd1) begin
                        w_last_nx  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_last_nx  = 1'b0;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_rem_nx   = '0;
                    w_mcnt_nx  = 4'd0;
                    w_valid_nx = 1'b0;
                    w_first_nx = 1'b0;
                    w_last_nx  = 1'b0;
                end
            endcase
        end
    end

    // State, counters and step outputs; reset aborts any sequence at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cls   <= SH_SLL;
            r_rem   <= '0;
            r_mcnt  <= 4'd0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cls   <= w_cls_nx;
            r_rem   <= w_rem_nx;
            r_mcnt  <= w_mcnt_nx;
            r_valid <= w_valid_nx;
            r_first <= w_first_nx;
            r_last  <= w_last_nx;
            r_ctrl  <= w_ctrl_nx;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.step_valid = r_valid;
    assign bus.step_first = r_first;
    assign bus.step_last  = r_last;
    assign bus.ALUctrl    = r_ctrl;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: decode table, hand-written multi-cycle
// sequences, and randomized traffic against a queue-based step model.
module tb_alu_seq_ctrl;

    localparam int SHAMT_W     = 5;
    localparam int MULT_CYCLES = 4;
    localparam int CTRL_W      = 6;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_seq_ctrl_if #(.SHAMT_W(SHAMT_W), .CTRL_W(CTRL_W)) bus ();

    alu_seq_ctrl #(
        .SHAMT_W     (SHAMT_W),
        .MULT_CYCLES (MULT_CYCLES),
        .CTRL_W      (CTRL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0] code;
        logic       first;
        logic       last;
    } step_t;

    typedef struct {
        logic [4:0] op;
        logic [5:0] fn;
        logic [4:0] sh;
        logic [5:0] code;
    } vec_t;

    step_t      mq[$];
    logic [5:0] m_ctrl;
    logic       m_valid;
    logic       m_first;
    logic       m_last;
    int         errors = 0;
    int         checks = 0;
    vec_t       vt[26];
    logic [5:0] fn_list[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand one operation into its full list of steps from the decode rules
    function automatic void model_accept(input logic [4:0] op, input logic [5:0] fn, input logic [4:0] sh);
        logic [5:0] codes[$];
        logic [5:0] c8, c2, c1;
        int s;
        int n;
        s = int'(sh);
        c8 = 6'h0C; c2 = 6'h0B; c1 = 6'h0A;
        case (op)
            5'd0: codes.push_back(6'h02);
            5'd1: codes.push_back(6'h06);
            5'd3: codes.push_back(6'h03);
            5'd4: codes.push_back(6'h00);
            5'd5: codes.push_back(6'h01);
            5'd6: codes.push_back(6'h04);
            5'd7: codes.push_back(6'h07);
            5'd8: codes.push_back(6'h08);
            5'd9: codes.push_back(6'h09);
            5'd2: begin
                case (fn)
                    6'h20: codes.push_back(6'h02);
                    6'h21: codes.push_back(6'h03);
                    6'h23: codes.push_back(6'h06);
                    6'h24: codes.push_back(6'h00);
                    6'h25: codes.push_back(6'h01);
                    6'h26: codes.push_back(6'h04);
                    6'h2A: codes.push_back(6'h07);
                    6'h2B: codes.push_back(6'h08);
                    6'h32: codes.push_back(6'h32);
                    6'h19: begin
                        for (int i = 0; i < MULT_CYCLES; i++) codes.push_back(6'h13);
                    end
                    6'h00, 6'h02, 6'h03: begin
                        if (fn == 6'h02) begin c8 = 6'h0F; c2 = 6'h0E; c1 = 6'h0D; end
                        if (fn == 6'h03) begin c8 = 6'h12; c2 = 6'h11; c1 = 6'h10; end
                        if (s == 0) codes.push_back(6'h00);
                        for (int i = 0; i < s / 8; i++) codes.push_back(c8);
                        for (int i = 0; i < (s % 8) / 2; i++) codes.push_back(c2);
                        for (int i = 0; i < s % 2; i++) codes.push_back(c1);
                    end
                    default: codes.push_back(6'h00);
                endcase
            end
            default: codes.push_back(6'h00);
        endcase
        n = codes.size();
        for (int i = 0; i < n; i++) mq.push_back('{code: codes[i], first: (i == 0), last: (i == n - 1)});
    endfunction

    task automatic set_in(input logic v, input logic [4:0] op, input logic [5:0] fn, input logic [4:0] sh);
        bus.in_valid     = v;
        bus.ALUop        = op;
        bus.functionCode = fn;
        bus.Shamt        = sh;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it
    task automatic do_cycle();
        logic  exp_ready;
        step_t s;
        @(negedge clk);
        exp_ready = (mq.size() == 0) && !bus.hold && !bus.flush;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        if (bus.flush) begin
            mq.delete();
            m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0;
        end else if (bus.hold) begin
            m_valid = m_valid;
        end else begin
            if (mq.size() == 0 && bus.in_valid) model_accept(bus.ALUop, bus.functionCode, bus.Shamt);
            if (mq.size() != 0) begin
                s = mq.pop_front();
                m_valid = 1'b1; m_ctrl = s.code; m_first = s.first; m_last = s.last;
            end else begin
                m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("model_valid", 32'(bus.step_valid), 32'(m_valid));
        chk("model_ctrl",  32'(bus.ALUctrl),    32'(m_ctrl));
        chk("model_first", 32'(bus.step_first), 32'(m_first));
        chk("model_last",  32'(bus.step_last),  32'(m_last));
        chk("model_busy",  32'(bus.busy),       32'(mq.size() != 0));
    endtask

    // Present an op, then check n steps against a constant code list
    task automatic check_seq(input string name, input logic [4:0] op, input logic [5:0] fn,
                             input logic [4:0] sh, input logic [5:0] exp[8], input int n);
        set_in(1'b1, op, fn, sh);
        for (int k = 0; k < n; k++) begin
            do_cycle();
            if (k == 0) bus.in_valid = 1'b0;
            chk({name, "_code"},  32'(bus.ALUctrl),    32'(exp[k]));
            chk({name, "_valid"}, 32'(bus.step_valid), 32'd1);
            chk({name, "_first"}, 32'(bus.step_first), 32'(k == 0));
            chk({name, "_last"},  32'(bus.step_last),  32'(k == n - 1));
            chk({name, "_ready"}, 32'(bus.in_ready),   32'(k == n - 1));
        end
    endtask

    initial begin
        vt[0]  = '{5'd0,  6'h00, 5'd0, 6'h02};
        vt[1]  = '{5'd1,  6'h00, 5'd0, 6'h06};
        vt[2]  = '{5'd3,  6'h00, 5'd0, 6'h03};
        vt[3]  = '{5'd4,  6'h00, 5'd0, 6'h00};
        vt[4]  = '{5'd5,  6'h00, 5'd0, 6'h01};
        vt[5]  = '{5'd6,  6'h00, 5'd0, 6'h04};
        vt[6]  = '{5'd7,  6'h00, 5'd0, 6'h07};
        vt[7]  = '{5'd8,  6'h00, 5'd0, 6'h08};
        vt[8]  = '{5'd9,  6'h00, 5'd0, 6'h09};
        vt[9]  = '{5'd10, 6'h20, 5'd0, 6'h00};
        vt[10] = '{5'd2,  6'h20, 5'd0, 6'h02};
        vt[11] = '{5'd2,  6'h21, 5'd0, 6'h03};
        vt[12] = '{5'd2,  6'h23, 5'd0, 6'h06};
        vt[13] = '{5'd2,  6'h24, 5'd0, 6'h00};
        vt[14] = '{5'd2,  6'h25, 5'd0, 6'h01};
        vt[15] = '{5'd2,  6'h26, 5'd0, 6'h04};
        vt[16] = '{5'd2,  6'h2A, 5'd0, 6'h07};
        vt[17] = '{5'd2,  6'h2B, 5'd0, 6'h08};
        vt[18] = '{5'd2,  6'h32, 5'd0, 6'h32};
        vt[19] = '{5'd2,  6'h10, 5'd0, 6'h00};
        vt[20] = '{5'd2,  6'h26, 5'd0, 6'h04};
        vt[21] = '{5'd2,  6'h12, 5'd0, 6'h00};
        vt[22] = '{5'd2,  6'h3F, 5'd0, 6'h00};
        vt[23] = '{5'd2,  6'h02, 5'd0, 6'h00};
        vt[24] = '{5'd2,  6'h00, 5'd1, 6'h0A};
        vt[25] = '{5'd2,  6'h03, 5'd2, 6'h11};
        fn_list = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B,
                    6'h32, 6'h10, 6'h12, 6'h19, 6'h00, 6'h02, 6'h03, 6'h3F};

        m_ctrl = 6'h00; m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0;
        bus.hold = 1'b0;
        bus.flush = 1'b0;
        rst_n = 1'b0;
        set_in(1'b1, 5'd2, 6'h20, 5'd0);

        // Reset: registered outputs held at zero while an op is presented
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.step_valid), 32'd0);
        chk("rst_first", 32'(bus.step_first), 32'd0);
        chk("rst_last",  32'(bus.step_last),  32'd0);
        chk("rst_busy",  32'(bus.busy),       32'd0);
        chk("rst_ctrl",  32'(bus.ALUctrl),    32'd0);
        rst_n = 1'b1;

        // First accept after reset: ADD via funct 0x20
        do_cycle();
        chk("add_ctrl",  32'(bus.ALUctrl),    32'h02);
        chk("add_valid", 32'(bus.step_valid), 32'd1);
        chk("add_first", 32'(bus.step_first), 32'd1);
        chk("add_last",  32'(bus.step_last),  32'd1);
        chk("add_ready", 32'(bus.in_ready),   32'd1);

        // Decode table, back-to-back single-step ops
        for (int i = 0; i < 26; i++) begin
            set_in(1'b1, vt[i].op, vt[i].fn, vt[i].sh);
            do_cycle();
            chk("tbl_code",  32'(bus.ALUctrl),    32'(vt[i].code));
            chk("tbl_valid", 32'(bus.step_valid), 32'd1);
            chk("tbl_first", 32'(bus.step_first), 32'd1);
            chk("tbl_last",  32'(bus.step_last),  32'd1);
        end
        set_in(1'b0, 5'd0, 6'h00, 5'd0);
        do_cycle();
        chk("idle_valid", 32'(bus.step_valid), 32'd0);

        // Multi-step shifts and shift-by-zero
        check_seq("sll13", 5'd2, 6'h00, 5'd13,
                  '{6'h0C, 6'h0B, 6'h0B, 6'h0A, 6'h00, 6'h00, 6'h00, 6'h00}, 4);
        check_seq("sra31", 5'd2, 6'h03, 5'd31,
                  '{6'h12, 6'h12, 6'h12, 6'h11, 6'h11, 6'h11, 6'h10, 6'h00}, 7);
        check_seq("srl0", 5'd2, 6'h02, 5'd0,
                  '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00}, 1);

        // MULTU with a second op waiting: taken in the final step cycle
        set_in(1'b1, 5'd2, 6'h19, 5'd0);
        do_cycle();
        set_in(1'b1, 5'd5, 6'h00, 5'd0);
        for (int k = 0; k < MULT_CYCLES; k++) begin
            if (k > 0) do_cycle();
            chk("mul_code",  32'(bus.ALUctrl),   32'h13);
            chk("mul_last",  32'(bus.step_last), 32'(k == MULT_CYCLES - 1));
            chk("mul_ready", 32'(bus.in_ready),  32'(k == MULT_CYCLES - 1));
        end
        do_cycle();
        chk("mul_next_code",  32'(bus.ALUctrl),    32'h01);
        chk("mul_next_first", 32'(bus.step_first), 32'd1);

        // Hold for 3 cycles on step 2 of SLL 13
        set_in(1'b1, 5'd2, 6'h00, 5'd13);
        do_cycle();
        bus.in_valid = 1'b0;
        do_cycle();
        chk("hold_pre", 32'(bus.ALUctrl), 32'h0B);
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_cycle();
            chk("hold_code",  32'(bus.ALUctrl),    32'h0B);
            chk("hold_valid", 32'(bus.step_valid), 32'd1);
            chk("hold_ready", 32'(bus.in_ready),   32'd0);
        end
        bus.hold = 1'b0;
        do_cycle();
        chk("hold_s3", 32'(bus.ALUctrl), 32'h0B);
        chk("hold_s3_last", 32'(bus.step_last), 32'd0);
        do_cycle();
        chk("hold_s4", 32'(bus.ALUctrl), 32'h0A);
        chk("hold_s4_last", 32'(bus.step_last), 32'd1);

        // Flush at step 2 of SLL 13, then ALUop 5 accepted the next cycle
        set_in(1'b1, 5'd2, 6'h00, 5'd13);
        do_cycle();
        bus.in_valid = 1'b0;
        do_cycle();
        set_in(1'b1, 5'd5, 6'h00, 5'd0);
        bus.flush = 1'b1;
        do_cycle();
        chk("flush_valid", 32'(bus.step_valid), 32'd0);
        chk("flush_busy",  32'(bus.busy),       32'd0);
        bus.flush = 1'b0;
        do_cycle();
        chk("flush_next_code",  32'(bus.ALUctrl),    32'h01);
        chk("flush_next_valid", 32'(bus.step_valid), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            bus.in_valid     = ($urandom_range(0, 9) < 7);
            bus.ALUop        = ($urandom_range(0, 9) < 5) ? 5'd2 : 5'($urandom_range(0, 11));
            bus.functionCode = ($urandom_range(0, 9) < 8) ? fn_list[$urandom_range(0, 15)] : 6'($urandom);
            bus.Shamt        = 5'($urandom);
            bus.hold         = ($urandom_range(0, 9) == 0);
            bus.flush        = ($urandom_range(0, 39) == 0);
            do_cycle();
        end
        bus.hold = 1'b0;
        bus.flush = 1'b0;

        // Asynchronous reset in the middle of a long shift
        set_in(1'b1, 5'd2, 6'h03, 5'd31);
        do_cycle();
        bus.in_valid = 1'b0;
        do_cycle();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.step_valid), 32'd0);
        chk("arst_busy",  32'(bus.busy),       32'd0);
        chk("arst_ctrl",  32'(bus.ALUctrl),    32'd0);
        mq.delete();
        m_ctrl = 6'h00; m_valid = 1'b0; m_first = 1'b0; m_last = 1'b0;
        #1;
        rst_n = 1'b1;
        do_cycle();
        chk("arst_after_valid", 32'(bus.step_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
